// File: rtl/alu_rr_scheduler.sv
// Purpose : round-robin scheduler sharing one external 8-bit ALU between NREQ requesters.
// Latency : accept cycle T, ALU evaluates in T+1, response valid from T+2 (T+1 for rejected opcodes).
// Backpr. : one op in flight; no new request is accepted until the response handshakes.
//
// Ports:
//   clk, rst_n                  clock (rising edge) and async active-low reset
//   req_valid/req_ready         per-requester handshake; req_ready is one-hot or zero
//   req_op/req_a/req_b          packed per-requester opcode (4b) and operands (8b)
//   rsp_valid/rsp_ready         single response channel
//   rsp_id/rsp_result/rsp_flags response tag, ALU result, {carry, overflow, zero, negative}
//   rsp_err                     illegal-opcode indication
//   busy                        high whenever an operation is in flight
//   alu_a/alu_b/alu_sel         registered operands/opcode to the external ALU
//   alu_result/alu_*            combinational ALU outputs
//
// Optional build macro: ALU_ILLEGAL_OP_CHECK_EN -- opcodes above 4'b1010 bypass the
// ALU and return result 0, flags 0, rsp_err=1 one cycle after acceptance.
module alu_rr_scheduler #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_op,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_result,
    output logic [3:0]          rsp_flags,
    output logic                rsp_err,
    output logic                busy,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_sel,
    input  logic [7:0]          alu_result,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                alu_zero,
    input  logic                alu_negative
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q;

    logic [NREQ-1:0]    gnt_vec;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [3:0]         sel_op;
    logic [7:0]         sel_a, sel_b;
    logic [IDW:0]       cand;
    logic               accept;
    logic               skip_issue;

    // Search starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any && (cand == (IDW+1)'(i)) && req_valid[i]) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = IDW'(i);
                    gnt_vec[i] = 1'b1;
                    sel_op     = req_op[4*i +: 4];
                    sel_a      = req_a[8*i +: 8];
                    sel_b      = req_b[8*i +: 8];
                end
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && gnt_any;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign skip_issue = accept && (sel_op > 4'b1010);
`else
    assign skip_issue = 1'b0;
`endif

    // Gated by rst_n so no grant is advertised while reset is held.
    assign req_ready = gnt_vec & {NREQ{rst_n && (state_q == ST_IDLE)}};
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)    state_d = skip_issue ? ST_RESP : ST_ISSUE;
            ST_ISSUE:                state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDW'(NREQ-1);
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
        end else begin
            if (accept) begin
                rsp_id <= gnt_idx;
                ptr_q  <= gnt_idx;
                // Rejected opcodes never reach the ALU, so its inputs keep the last issue.
                if (!skip_issue) begin
                    alu_sel <= sel_op;
                    alu_a   <= sel_a;
                    alu_b   <= sel_b;
                end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
                if (skip_issue) begin
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                end
`endif
            end
            if (state_q == ST_ISSUE) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carry, alu_overflow, alu_zero, alu_negative};
            end
        end
    end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= skip_issue;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Purpose : self-checking bench for alu_rr_scheduler with a behavioural ALU attached.
// Latency : n/a (drives inputs and samples outputs on the falling edge).
// Backpr. : exercises rsp_ready stalls, directed and randomized.
module tb_alu_rr_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd4, OP_DIV = 4'd9;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op = '0;
    logic [8*NREQ-1:0]   req_a = '0;
    logic [8*NREQ-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_result;
    logic [3:0]          rsp_flags;
    logic                rsp_err;
    logic                busy;
    logic [7:0]          alu_a, alu_b;
    logic [3:0]          alu_sel;
    logic [7:0]          alu_result;
    logic                alu_carry, alu_overflow, alu_zero, alu_negative;
    logic [11:0]         alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative)
    );

    // Behavioural ALU: returns {result, carry, overflow, zero, negative}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd7:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd8:  begin w = 9'(a * b); r = w[7:0]; end
            4'd9:  r = (b == 8'd0) ? 8'd0 : a / b;
            4'd10: r = (b == 8'd0) ? 8'd0 : a % b;
            default: r = 8'd0;
        endcase
        return {r, c, v, (r == 8'd0), r[7]};
    endfunction

    assign alu_out      = alu_f(alu_sel, alu_a, alu_b);
    assign alu_result   = alu_out[11:4];
    assign alu_carry    = alu_out[3];
    assign alu_overflow = alu_out[2];
    assign alu_zero     = alu_out[1];
    assign alu_negative = alu_out[0];

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy, alu_a, alu_b, alu_sel} !== '0)
            begin n_fail++; $display("FAIL reset_values got rdy=%b v=%b id=%0d res=%h fl=%b err=%b busy=%b a=%h b=%h sel=%h exp all zero",
                req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy, alu_a, alu_b, alu_sel); end
        do_reset();
    endtask

    task automatic test_add();
        req_op[3:0] = OP_ADD; req_a[7:0] = 8'h7F; req_b[7:0] = 8'h01;
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL add_issue got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy); end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency rsp_valid got %b exp 1", rsp_valid); end
        n_checks++;
        if ({rsp_id, rsp_result, rsp_flags, rsp_err} !== {2'd0, 8'h80, 4'b0101, 1'b0})
            begin n_fail++; $display("FAIL add_resp got id=%0d res=%h fl=%b err=%b exp id=0 res=80 fl=0101 err=0", rsp_id, rsp_result, rsp_flags, rsp_err); end
        n_checks++;
        if ({alu_sel, alu_a, alu_b} !== {OP_ADD, 8'h7F, 8'h01})
            begin n_fail++; $display("FAIL add_alu_hold got sel=%h a=%h b=%h exp 0 7f 01", alu_sel, alu_a, alu_b); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL add_done got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_pair_sub();
        int          ids[$];
        logic [11:0] rs[$];
        logic [NREQ-1:0] acc;
        do_reset();
        req_op = {OP_SUB, OP_SUB}; req_a = {8'h05, 8'h05}; req_b = {8'h05, 8'h05};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL pair_first_grant got %b exp 01", req_ready); end
        for (int c = 0; c < 20 && ids.size() < 2; c++) begin
            acc = req_valid & req_ready;
            if (rsp_valid && rsp_ready) begin
                ids.push_back(int'(rsp_id));
                rs.push_back({rsp_result, rsp_flags});
            end
            @(negedge clk);
            req_valid = req_valid & ~acc;
            #1;
        end
        n_checks++;
        if (ids.size() != 2) begin
            n_fail++; $display("FAIL pair_count got %0d responses exp 2", ids.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (ids[i] != i) begin n_fail++; $display("FAIL pair_order[%0d] got id %0d exp %0d", i, ids[i], i); end
                n_checks++;
                if (rs[i] !== {8'h00, 4'b0010}) begin n_fail++; $display("FAIL pair_result[%0d] got %h exp 002", i, rs[i]); end
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_alternate();
        int order[$];
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            req_op = NREQ*4'($urandom_range(0, 10)); req_a = 16'($urandom); req_b = 16'($urandom);
            #1;
            n_checks++;
            if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL alt_onehot got %b exp at most one bit", req_ready); end
            if (req_ready != '0) order.push_back(req_ready[1] ? 1 : 0);
            @(negedge clk);
        end
        n_checks++;
        if (order.size() != 6) begin n_fail++; $display("FAIL alt_count got %0d grants exp 6", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_checks++;
            if (order[i] != i % 2) begin n_fail++; $display("FAIL alt_order[%0d] got %0d exp %0d", i, order[i], i % 2); end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_div_hold();
        int hs;
        do_reset();
        req_op[7:4] = OP_DIV; req_a[15:8] = 8'h10; req_b[15:8] = 8'h00;
        req_valid = 2'b10;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL div_grant got %b exp 10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err} !== {1'b1, 2'd1, 8'h00, 4'b0010, 1'b0})
                begin n_fail++; $display("FAIL div_hold cyc %0d got v=%b id=%0d res=%h fl=%b err=%b exp v=1 id=1 res=00 fl=0010 err=0",
                    c, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid && rsp_ready) hs++;
        @(negedge clk);
        #1;
        if (rsp_valid && rsp_ready) hs++;
        rsp_ready = 1'b0;
        n_checks++;
        if (hs != 1) begin n_fail++; $display("FAIL div_handshakes got %0d exp 1", hs); end
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL div_busy_drop got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_op[3:0] = OP_AND; req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_issue busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy, alu_a, alu_b, alu_sel} !== '0)
            begin n_fail++; $display("FAIL mid_reset_values got v=%b busy=%b res=%h a=%h b=%h sel=%h exp all zero",
                rsp_valid, busy, rsp_result, alu_a, alu_b, alu_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp cyc %0d got rsp_valid %b exp 0", c, rsp_valid); end
        end
        req_op = {OP_ADD, OP_AND}; req_a = {8'h01, 8'hF0}; req_b = {8'h01, 8'h3C};
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_next_grant got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd0, 8'h30, 4'b0000})
            begin n_fail++; $display("FAIL mid_after_resp got v=%b id=%0d res=%h fl=%b exp v=1 id=0 res=30 fl=0000", rsp_valid, rsp_id, rsp_result, rsp_flags); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        req_op[3:0] = OP_XOR; req_a[7:0] = 8'h0F; req_b[7:0] = 8'hF0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_op[3:0] = 4'b1100; req_a[7:0] = 8'h33; req_b[7:0] = 8'($urandom);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_grant got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== {1'b1, 8'h00, 4'b0000, 1'b1})
            begin n_fail++; $display("FAIL ill_resp got v=%b res=%h fl=%b err=%b exp v=1 res=00 fl=0000 err=1", rsp_valid, rsp_result, rsp_flags, rsp_err); end
        n_checks++;
        if ({alu_sel, alu_a} !== {OP_XOR, 8'h0F})
            begin n_fail++; $display("FAIL ill_alu_unchanged got sel=%h a=%h exp 4 0f", alu_sel, alu_a); end
`else
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ill_issue got rsp_valid %b exp 0", rsp_valid); end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_flags, rsp_err} !== {1'b1, 8'h00, 4'b0010, 1'b0})
            begin n_fail++; $display("FAIL ill_resp got v=%b res=%h fl=%b err=%b exp v=1 res=00 fl=0010 err=0", rsp_valid, rsp_result, rsp_flags, rsp_err); end
        n_checks++;
        if (alu_sel !== 4'b1100) begin n_fail++; $display("FAIL ill_alu_sel got %h exp c", alu_sel); end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ill_done busy got %b exp 0", busy); end
    endtask

    // Reference: one op outstanding at a time; grant = first valid requester after the
    // last winner; response appears 2 cycles after the accept cycle (1 if rejected).
    task automatic test_random();
        int              ptr, g, rdy_cyc, nresp;
        bit              pend, ill;
        logic [NREQ-1:0] exp_rdy;
        logic [3:0]      lsel, op;
        logic [7:0]      la, lb;
        logic [IDW-1:0]  e_id;
        logic [11:0]     e_rf;
        logic            e_err, e_vld;
        do_reset();
        ptr = NREQ - 1; pend = 1'b0; rdy_cyc = 0; nresp = 0;
        lsel = '0; la = '0; lb = '0; e_id = '0; e_rf = '0; e_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_op[4*i +: 4] = 4'($urandom_range(0, 12));
                req_a[8*i +: 8]  = 8'($urandom);
                req_b[8*i +: 8]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            g = -1;
            exp_rdy = '0;
            if (!pend) begin
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            e_vld = pend && (cyc >= rdy_cyc);
            n_checks++;
            if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, exp_rdy); end
            n_checks++;
            if ({busy, rsp_valid} !== {pend, e_vld}) begin n_fail++; $display("FAIL rnd_state cyc %0d got busy=%b v=%b exp busy=%b v=%b", cyc, busy, rsp_valid, pend, e_vld); end
            n_checks++;
            if ({alu_sel, alu_a, alu_b} !== {lsel, la, lb}) begin n_fail++; $display("FAIL rnd_alu cyc %0d got %h %h %h exp %h %h %h", cyc, alu_sel, alu_a, alu_b, lsel, la, lb); end
            if (e_vld) begin
                n_checks++;
                if ({rsp_id, rsp_result, rsp_flags, rsp_err} !== {e_id, e_rf, e_err})
                    begin n_fail++; $display("FAIL rnd_resp cyc %0d got id=%0d res=%h fl=%b err=%b exp id=%0d res=%h fl=%b err=%b",
                        cyc, rsp_id, rsp_result, rsp_flags, rsp_err, e_id, e_rf[11:4], e_rf[3:0], e_err); end
            end
            if (g >= 0) begin
                op   = req_op[4*g +: 4];
                ill  = ILL_EN && (op > 4'd10);
                pend = 1'b1;
                ptr  = g;
                e_id = IDW'(g);
                rdy_cyc = cyc + (ill ? 1 : 2);
                e_err = ill;
                e_rf  = ill ? 12'h000 : alu_f(op, req_a[8*g +: 8], req_b[8*g +: 8]);
                if (!ill) begin lsel = op; la = req_a[8*g +: 8]; lb = req_b[8*g +: 8]; end
            end else if (e_vld && rsp_ready) begin
                pend = 1'b0;
                nresp++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (nresp < 50) begin n_fail++; $display("FAIL rnd_progress got %0d responses exp at least 50", nresp); end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_pair_sub();
        test_alternate();
        test_div_hold();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one external alu_8bit datapath between NREQ requesters.
- Round-robin arbitration; captures the winner's operands and opcode, drives the ALU for one cycle, then registers result and flags.
- Returns result and flags on a single response channel tagged with the requester ID.
- Sits between client blocks (sequencers, test engines) and the single ALU instance.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_op  input  4*NREQ  opcode for requester i in bits [4i+3:4i].
- req_a  input  8*NREQ  operand A for requester i in bits [8i+7:8i].
- req_b  input  8*NREQ  operand B for requester i in bits [8i+7:8i].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester this response belongs to.
- rsp_result  output  8  registered ALU result.
- rsp_flags  output  4  registered flags {carry, overflow, zero, negative}.
- rsp_err  output  1  illegal-opcode indication (see Optional Feature).
- busy  output  1  high in every state other than IDLE.
- alu_a  output  8  operand A to ALU.
- alu_b  output  8  operand B to ALU.
- alu_sel  output  4  opcode to ALU.
- alu_result  input  8  ALU result (combinational).
- alu_carry, alu_overflow, alu_zero, alu_negative  input  1 each  ALU flags.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0x00, rsp_flags=4'b0000, rsp_err=0, busy=0, alu_a=alu_b=0x00, alu_sel=4'b0000. Round-robin pointer resets to NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: if any req_valid is high, search from pointer+1 (mod NREQ) and grant the first requester with req_valid high. req_ready[g] is combinational from req_valid and the pointer, and is high only in IDLE. On the accepting edge, register op/A/B into alu_sel/alu_a/alu_b, register g into rsp_id, set pointer=g, and go to ISSUE.
  - ISSUE (exactly 1 cycle): the ALU evaluates the registered operands. At the end of the cycle, capture alu_result into rsp_result and the four ALU flags into rsp_flags, then go to RESP.
  - RESP: rsp_valid=1. Result, flags, ID and err stay stable until rsp_valid&&rsp_ready, then go to IDLE.
- Acceptance is blocked in RESP even when rsp_ready=1. Throughput is therefore at most 1 operation per 3 cycles.
- Latency: accept on edge T; rsp_valid is high from edge T+2.
- alu_a, alu_b and alu_sel hold the last issued values while in IDLE and RESP.
- No requester is granted twice in a row while another requester has req_valid high.
- A requester that drops req_valid before being accepted is not serviced and does not move the pointer.
- No internal arithmetic: results are whatever the ALU returns, including 0x00 for divide-by-zero.
- Reset mid-operation: asserting rst_n low in any state immediately returns all outputs to their reset values, the FSM to IDLE and the pointer to NREQ-1. The in-flight operation is discarded with no response.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_CHECK_EN.
- Defined: an opcode greater than 4'b1010 is still accepted, but ISSUE is skipped and the FSM goes IDLE->RESP. The response carries rsp_result=0x00, rsp_flags=4'b0000, rsp_err=1. alu_* ports are not updated. Latency is 1 cycle.
- Not defined: every opcode is forwarded to the ALU on the normal path, and rsp_err is tied to 0.

Test Plan:
- Req0 ADD, A=0x7F, B=0x01 -> rsp_valid 2 cycles after accept; rsp_id=0, rsp_result=0x80, flags C=0 V=1 Z=0 N=1.
- Req0 and req1 valid together right after reset, both SUB with A=0x05, B=0x05 -> req0 served first (result 0x00, Z=1), then req1; responses in ID order 0, 1.
- Both requesters held valid for 6 operations -> grant order alternates 0,1,0,1,0,1; at most one req_ready bit high in any cycle.
- Req1 DIV, A=0x10, B=0x00; rsp_ready held low for 5 cycles -> rsp_valid, rsp_result=0x00 and Z=1 held stable for all 5 cycles; single handshake; busy drops the cycle after it.
- rst_n pulsed low during ISSUE of an AND -> no rsp_valid for that operation; next request from req0 is granted first and completes normally.
- Req0 opcode 4'b1100, A=0x33 -> with the macro: rsp_err=1, result 0x00, rsp_valid 1 cycle after accept, alu_sel unchanged. Without the macro: rsp_err=0, alu_sel=4'b1100, result 0x00 with Z=1.
